match_report_sender: RTL and testbench
======================================

# match_report_sender

Buffers match coordinates from the SAD scan and sends each one as a framed byte record through the shared byte-wide UART transmitter. After the last record, the block pulses `send_complete` so the control unit can move on. It sits between the top-level valid/x/y match outputs and the UART TX core. Once a scan ends, it appends one end-of-scan record so the host always receives a terminator.

## Interface
- `DEPTH`, default 4: match FIFO depth. Must be a power of two, at least 2.
- `HDR_MATCH`, default 8'hA5: header byte of a match record.
- `HDR_END`, default 8'h5A: header byte of the end-of-scan record.

- `clock`  in  1  — the single clock; all state changes on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `match_valid`  in  1  — one-cycle strobe; `match_x`/`match_y` are valid this cycle.
- `match_x`  in  10  — column of the match.
- `match_y`  in  9  — row of the match.
- `scan_done`  in  1  — one-cycle strobe; the whole image has been scanned.
- `tx_busy`  in  1  — UART TX is shifting a byte.
- `tx_data`  out  8  — byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1  — one-cycle request to the UART TX.
- `send_complete`  out  1  — one-cycle pulse after each record's last byte has finished.
- `overflow`  out  1  — sticky; a match was dropped because the FIFO was full.
- `busy`  out  1  — high in every state except IDLE, or while the FIFO is non-empty.

## Operation
- **FIFO**
  - Each entry is 19 bits, {y, x}.
  - A push happens on `match_valid` when the FIFO is not full.
  - When the FIFO is full, the match is dropped and `overflow` is set to 1. It clears only on reset.
  - Push and pop in the same cycle are both allowed; the count stays unchanged.
- **End pending flag**
  - `scan_done` sets an end-pending flag.
  - The end record is sent only after the FIFO has drained, so it always follows every buffered match.
- **Match record**, 5 bytes in this order:
  1. `HDR_MATCH`
  2. {6'b0, x[9:8]}
  3. x[7:0]
  4. {7'b0, y[8]}
  5. y[7:0]
- **End record**, 5 bytes: `HDR_END`, then 8'hFF four times.
- **FSM states**: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, ADVANCE, DONE.
  - IDLE:
    - If the FIFO is non-empty: pop the head into the record register, set byte index to 0, go to LOAD.
    - Else if end-pending: load the end record, clear end-pending, go to LOAD.
    - The FIFO takes priority over end-pending.
  - LOAD: drive `tx_data` with the byte at the current index; go to START.
  - START: wait until `tx_busy`=0, then assert `tx_start` for one cycle and go to WAIT_ACK.
  - WAIT_ACK: wait for `tx_busy`=1, then go to WAIT_DONE.
    - If `tx_busy` is still 0 after 4 cycles, treat the byte as sent and go to ADVANCE. This is the lost-ack guard.
  - WAIT_DONE: when `tx_busy`=0, go to ADVANCE.
  - ADVANCE:
    - If the index is 4, go to DONE.
    - Otherwise increment the index and go to LOAD.
  - DONE: assert `send_complete` for one cycle, then go to IDLE.
- **Byte index**: 3 bits, values 0–4. It never wraps past 4.
- **Reset** (including mid-record):
  - FSM returns to IDLE and the FIFO is emptied.
  - End-pending and `overflow` clear.
  - `tx_start`=0, `tx_data`=8'h00, `send_complete`=0, `busy`=0.
  - A byte already started is not recalled; the UART TX is responsible for finishing or aborting it.

## Timing
- Output timing:
  - `tx_start` and `send_complete` are registered.
  - `tx_data` is registered and changes only in LOAD.
- Minimum latency from `match_valid` to the first `tx_start`, with `tx_busy`=0 throughout, is 4 cycles:
  - push at edge 1, IDLE pop at edge 2, LOAD at edge 3, `tx_start` is high after edge 4.
- Per byte, the overhead beyond the UART byte time is 3 cycles: ADVANCE, LOAD, START.
- A record is 5 bytes. `send_complete` rises 2 cycles after `tx_busy` falls for byte 5.
- Simultaneous `match_valid` and `scan_done`: the match is pushed and end-pending is set. The end record follows that match.
- `scan_done` while end-pending is already set has no additional effect; only one end record is sent.
- `busy` is combinational from state and FIFO count.

## Test plan
- **Single match**: match (x=10'h2A7, y=9'h1C3), with a TX model that raises busy 1 cycle after start and holds it 10 cycles.
  - Bytes A5, 02, A7, 01, C3 are sent.
  - One `send_complete` pulse follows.
- **Burst overflow**, DEPTH=4: 6 back-to-back `match_valid` while TX is busy.
  - Exactly 4 records are sent, in FIFO order.
  - `overflow`=1 from the 5th strobe until reset.
- **scan_done with 2 matches queued**:
  - Both match records are sent, then 5A FF FF FF FF.
  - 3 `send_complete` pulses in total.
- **Simultaneous strobes**: `match_valid` and `scan_done` in the same cycle with an empty FIFO.
  - The match record is sent first, then the end record.
  - Repeated `scan_done` strobes produce only one end record.
- **Lost ack**: TX model never raises busy.
  - Each byte advances 4 cycles after `tx_start`.
  - The record completes with `send_complete`.
- **Reset mid-record**: assert `reset` during WAIT_DONE of byte 3.
  - Next cycle: `busy`=0, `tx_start`=0, `overflow`=0.
  - A new match then sends a full 5-byte record starting with A5.

Source files
------------

// File: rtl/match_report_sender.sv
// Buffers SAD match coordinates and streams each one as a 5-byte framed record through
// the shared UART TX. An end-of-scan record follows the last buffered match of a scan.
module match_report_sender #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  HDR_MATCH = 8'hA5,
    parameter logic [7:0]  HDR_END   = 8'h5A
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       match_valid,
    input  logic [9:0] match_x,
    input  logic [8:0] match_y,
    input  logic       scan_done,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       send_complete,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned     PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW      = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitAck,
        StWaitDone,
        StAdvance,
        StDone
    } state_e;

    // FIFO of {y, x} entries
    logic [18:0]     fifo_mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            fifo_full, fifo_empty, push, pop;
    logic            overflow_q;

    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);
    assign push       = match_valid && !fifo_full;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {match_y, match_x};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (match_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    // Record sequencer
    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  ack_cnt_q, ack_cnt_d;
    logic [18:0] rec_q, rec_d;
    logic        rec_end_q, rec_end_d;
    logic        end_pend_q, end_pend_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        send_complete_q, send_complete_d;
    logic [7:0]  cur_byte;

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            3'd0:    cur_byte = rec_end_q ? HDR_END : HDR_MATCH;
            3'd1:    cur_byte = rec_end_q ? 8'hFF : {6'b0, rec_q[9:8]};
            3'd2:    cur_byte = rec_end_q ? 8'hFF : rec_q[7:0];
            3'd3:    cur_byte = rec_end_q ? 8'hFF : {7'b0, rec_q[18]};
            3'd4:    cur_byte = rec_end_q ? 8'hFF : rec_q[17:10];
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        ack_cnt_d       = ack_cnt_q;
        rec_d           = rec_q;
        rec_end_d       = rec_end_q;
        end_pend_d      = end_pend_q | scan_done;
        tx_data_d       = tx_data_q;
        tx_start_d      = 1'b0;
        send_complete_d = 1'b0;
        pop             = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    rec_d     = fifo_mem[rd_ptr_q];
                    rec_end_d = 1'b0;
                    idx_d     = 3'd0;
                    state_d   = StLoad;
                end else if (end_pend_q) begin
                    // A scan_done arriving now is absorbed by the record being loaded
                    rec_d      = '0;
                    rec_end_d  = 1'b1;
                    idx_d      = 3'd0;
                    end_pend_d = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                tx_data_d = cur_byte;
                state_d   = StStart;
            end
            StStart: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    ack_cnt_d  = 2'd0;
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (ack_cnt_q == 2'd3) begin
                    state_d = StAdvance;
                end else begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StAdvance;
            end
            StAdvance: begin
                if (idx_q == 3'd4) begin
                    send_complete_d = 1'b1;
                    state_d         = StDone;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            idx_q           <= 3'd0;
            ack_cnt_q       <= 2'd0;
            rec_q           <= '0;
            rec_end_q       <= 1'b0;
            end_pend_q      <= 1'b0;
            tx_data_q       <= 8'h00;
            tx_start_q      <= 1'b0;
            send_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            ack_cnt_q       <= ack_cnt_d;
            rec_q           <= rec_d;
            rec_end_q       <= rec_end_d;
            end_pend_q      <= end_pend_d;
            tx_data_q       <= tx_data_d;
            tx_start_q      <= tx_start_d;
            send_complete_q <= send_complete_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_start      = tx_start_q;
    assign send_complete = send_complete_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_match_report_sender.sv
// Scoreboard bench for match_report_sender: expected bytes are queued when matches or
// scan_done are driven and checked against each tx_start seen from the DUT.
module tb_match_report_sender;

    logic       clock = 1'b0;
    logic       reset;
    logic       match_valid;
    logic [9:0] match_x;
    logic [8:0] match_y;
    logic       scan_done;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       send_complete;
    logic       overflow;
    logic       busy;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    logic lost_ack   = 1'b0;
    assign tx_busy = model_busy | hold_busy;

    match_report_sender #(
        .DEPTH     (4),
        .HDR_MATCH (8'hA5),
        .HDR_END   (8'h5A)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .match_valid   (match_valid),
        .match_x       (match_x),
        .match_y       (match_y),
        .scan_done     (scan_done),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .send_complete (send_complete),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] sb_q[$];
    logic [7:0] mon_exp;
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int byte_cnt = 0;
    int sc_seen = 0;
    int sc_exp = 0;
    int last_start_cyc = 0;
    int fall_cyc = 0;
    int mdl_phase = 0;
    int mdl_left = 0;
    bit chk_sc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // UART TX model: busy rises one cycle after tx_start and stays high 10 cycles
    always @(negedge clock) begin
        if (mdl_phase == 1) begin
            model_busy = 1'b1;
            mdl_left   = 10;
            mdl_phase  = 2;
        end else if (mdl_phase == 2) begin
            mdl_left--;
            if (mdl_left == 0) begin
                model_busy = 1'b0;
                fall_cyc   = cyc;
                mdl_phase  = 0;
            end
        end else if (tx_start === 1'b1 && !lost_ack) begin
            mdl_phase = 1;
        end
    end

    // Output monitor
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (tx_start) begin
                if (sb_q.size() == 0) begin
                    check_eq("extra_start", 32'(tx_start), 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_eq("tx_byte", 32'(tx_data), 32'(mon_exp));
                end
                if (lost_ack && byte_cnt > 0) check_eq("lost_ack_gap", cyc - last_start_cyc, 7);
                last_start_cyc = cyc;
                byte_cnt++;
            end
            if (send_complete) begin
                check_eq("rec_len", byte_cnt, 5);
                if (chk_sc) check_eq("sc_delay", cyc - fall_cyc, 2);
                byte_cnt = 0;
                sc_seen++;
            end
        end
    end

    task automatic expect_match(input logic [9:0] x, input logic [8:0] y);
        sb_q.push_back(8'hA5);
        sb_q.push_back({6'b0, x[9:8]});
        sb_q.push_back(x[7:0]);
        sb_q.push_back({7'b0, y[8]});
        sb_q.push_back(y[7:0]);
        sc_exp++;
    endtask

    task automatic expect_end();
        sb_q.push_back(8'h5A);
        repeat (4) sb_q.push_back(8'hFF);
        sc_exp++;
    endtask

    // Called at a negedge; returns at the next negedge with match_valid low
    task automatic drive_match(input logic [9:0] x, input logic [8:0] y);
        match_x     = x;
        match_y     = y;
        match_valid = 1'b1;
        expect_match(x, y);
        @(negedge clock);
        match_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (20) @(negedge clock);
        check_eq({tag, "_drain"}, sb_q.size(), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_sc"}, sc_seen, sc_exp);
    endtask

    initial begin
        int lat;
        int n;
        reset       = 1'b1;
        match_valid = 1'b0;
        match_x     = '0;
        match_y     = '0;
        scan_done   = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_tx_data", 32'(tx_data), 0);
        check_eq("rst_sc", 32'(send_complete), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single match with latency and send_complete timing
        chk_sc      = 1'b1;
        match_x     = 10'h2A7;
        match_y     = 9'h1C3;
        match_valid = 1'b1;
        expect_match(10'h2A7, 9'h1C3);
        lat = 0;
        while (tx_start !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
            if (lat == 1) match_valid = 1'b0;
        end
        check_eq("latency", lat, 4);
        wait_idle("single");
        chk_sc = 1'b0;

        // Burst while a record is stalled: 4 accepted, 5th and 6th dropped
        hold_busy = 1'b1;
        drive_match(10'h101, 9'h011);
        repeat (5) @(negedge clock);
        check_eq("ovf_pre", 32'(overflow), 0);
        for (int i = 0; i < 6; i++) begin
            match_x     = 10'(i * 37 + 5);
            match_y     = 9'(i * 11 + 3);
            match_valid = 1'b1;
            if (i < 4) expect_match(match_x, match_y);
            @(negedge clock);
            check_eq("ovf_burst", 32'(overflow), (i >= 4) ? 32'd1 : 32'd0);
        end
        match_valid = 1'b0;
        hold_busy   = 1'b0;
        wait_idle("burst");
        check_eq("ovf_sticky", 32'(overflow), 1);

        // Two matches queued, then scan_done
        hold_busy = 1'b1;
        drive_match(10'h3FF, 9'h000);
        drive_match(10'h000, 9'h1FF);
        scan_done = 1'b1;
        expect_end();
        @(negedge clock);
        scan_done = 1'b0;
        hold_busy = 1'b0;
        wait_idle("scan2");

        // Simultaneous strobes, then repeated scan_done while end is pending
        match_x     = 10'h155;
        match_y     = 9'h0AA;
        match_valid = 1'b1;
        scan_done   = 1'b1;
        expect_match(10'h155, 9'h0AA);
        expect_end();
        @(negedge clock);
        match_valid = 1'b0;
        scan_done   = 1'b0;
        repeat (3) begin
            repeat (2) @(negedge clock);
            scan_done = 1'b1;
            @(negedge clock);
            scan_done = 1'b0;
        end
        wait_idle("simul");

        // Lost ack: TX never raises busy
        lost_ack = 1'b1;
        drive_match(10'h0F0, 9'h10F);
        wait_idle("lost");
        lost_ack = 1'b0;

        // Reset during WAIT_DONE of byte 3
        check_eq("ovf_before_rst", 32'(overflow), 1);
        drive_match(10'h2AA, 9'h155);
        n = 0;
        while (byte_cnt < 3 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_eq("reach_byte3", byte_cnt, 3);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        sb_q.delete();
        byte_cnt = 0;
        sc_exp--;
        @(negedge clock);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_tx_start", 32'(tx_start), 0);
        check_eq("mid_rst_ovf", 32'(overflow), 0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 0);
        check_eq("mid_rst_sc", 32'(send_complete), 0);
        reset = 1'b0;
        @(negedge clock);
        drive_match(10'h001, 9'h002);
        wait_idle("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 expected less");
        $fatal(1);
    end

endmodule
